// File: rtl/game_step_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_step_scheduler_pkg
// Brief    : Master-state encodings, scheduler FSM states, period helper.
// Revision : 1.0 - initial release
// ============================================================================
package game_step_scheduler_pkg;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_PLAY = 2'd1,
        MS_WIN  = 2'd2,
        MS_LOSE = 2'd3
    } master_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_REQ   = 2'd2
    } sched_state_t;

    // Saturating max(div_max - speedup, div_min) in 5 bits; never wraps.
    function automatic logic [4:0] calc_period(input logic [4:0] div_max,
                                               input logic [4:0] div_min,
                                               input logic [3:0] speedup);
        logic [4:0] w_diff;
        if ({1'b0, speedup} >= div_max) begin
            return div_min;
        end
        w_diff = div_max - {1'b0, speedup};
        return (w_diff < div_min) ? div_min : w_diff;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vs_frame_strobe.sv
`default_nettype none
// ============================================================================
// Module   : vs_frame_strobe
// Brief    : Synchronises raw VSYNC and emits a one-cycle pulse per falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module vs_frame_strobe (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vs,
    output logic o_frm
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync2_d;
    logic r_frm;

    // Registered detector gives a fixed three-cycle edge-to-strobe latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_sync2_d <= 1'b1;
            r_frm     <= 1'b0;
        end else begin
            r_sync1   <= i_vs;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
            r_frm     <= r_sync2_d & ~r_sync2;
        end
    end

    assign o_frm = r_frm;

endmodule
`default_nettype wire

// File: rtl/game_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : game_step_scheduler
// Brief    : Score-dependent step pacing with req/ack handshake to the datapath.
// Revision : 1.0 - initial release
// ============================================================================
module game_step_scheduler
    import game_step_scheduler_pkg::*;
#(
    parameter int FRAME_DIV_MAX = 5,
    parameter int FRAME_DIV_MIN = 1,
    parameter int LEVEL_STEP    = 2
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       VS,
    input  logic [1:0] MASTER_STATE,
    input  logic       PAUSE,
    input  logic [3:0] SCORE_IN,
    input  logic       STEP_ACK,
    output logic       STEP_REQ,
    output logic [3:0] PERIOD_OUT,
    output logic       OVERRUN
);

    localparam int         c_shift   = $clog2(LEVEL_STEP);
    localparam logic [4:0] c_div_max = 5'(FRAME_DIV_MAX);
    localparam logic [4:0] c_div_min = 5'(FRAME_DIV_MIN);

    logic         w_frm;
    logic [3:0]   w_speedup;
    logic [4:0]   w_period;
    logic         w_terminal;

    sched_state_t r_state;
    logic [3:0]   r_cnt;
    logic [3:0]   r_period;
    logic         r_req;
    logic         r_ovr;

    vs_frame_strobe u_strobe (
        .clk   (CLOCK),
        .rst_n (RESET),
        .i_vs  (VS),
        .o_frm (w_frm)
    );

    assign w_speedup  = SCORE_IN >> c_shift;
    assign w_period   = calc_period(c_div_max, c_div_min, w_speedup);
    assign w_terminal = (r_cnt == (r_period - 4'd1));

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_period <= c_div_max[3:0];
            r_req    <= 1'b0;
            r_ovr    <= 1'b0;
        end else if (MASTER_STATE != MS_PLAY) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_req   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 4'd0;
                    r_req <= 1'b0;
                    if (!PAUSE) begin
                        r_state  <= ST_COUNT;
                        r_period <= w_period[3:0];
                    end
                end
                ST_COUNT: begin
                    if (w_frm && !PAUSE) begin
                        if (w_terminal) begin
                            r_cnt    <= 4'd0;
                            r_req    <= 1'b1;
                            r_period <= w_period[3:0];
                            r_state  <= ST_REQ;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                ST_REQ: begin
                    // Counter keeps running so a late ack cannot stretch the cadence.
                    if (w_frm) begin
                        r_cnt <= w_terminal ? 4'd0 : r_cnt + 4'd1;
                    end
                    if (STEP_ACK) begin
                        r_req   <= 1'b0;
                        r_state <= ST_COUNT;
                    end else if (w_frm && w_terminal) begin
                        r_ovr <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign STEP_REQ   = r_req;
    assign PERIOD_OUT = r_period;
    assign OVERRUN    = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_game_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_step_scheduler
// Brief    : Scoreboard bench for game_step_scheduler request cadence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_step_scheduler;

    typedef struct {
        int frame;
        int period;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       vs;
    logic [1:0] master_state;
    logic       pause;
    logic [3:0] score;
    logic       ack_auto;
    logic       ack_man;
    logic       step_ack;
    logic       step_req;
    logic [3:0] period_out;
    logic       overrun;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   frame_no;
    bit   auto_ack;
    bit   req_q;

    assign step_ack = ack_auto | ack_man;

    game_step_scheduler #(
        .FRAME_DIV_MAX (5),
        .FRAME_DIV_MIN (1),
        .LEVEL_STEP    (2)
    ) dut (
        .CLOCK        (clk),
        .RESET        (rst_n),
        .VS           (vs),
        .MASTER_STATE (master_state),
        .PAUSE        (pause),
        .SCORE_IN     (score),
        .STEP_ACK     (step_ack),
        .STEP_REQ     (step_req),
        .PERIOD_OUT   (period_out),
        .OVERRUN      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed=%0d required=%0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic push(input int frame, input int period);
        exp_t e;
        e.frame  = frame;
        e.period = period;
        sb.push_back(e);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            vs = 1'b0;
            frame_no++;
            repeat (4) @(posedge clk);
            #1 vs = 1'b1;
            repeat (16) @(posedge clk);
        end
    endtask

    task automatic man_ack();
        @(posedge clk); #1 ack_man = 1'b1;
        @(posedge clk); #1 ack_man = 1'b0;
        chk("ack_drop", int'(step_req), 0);
    endtask

    // Each rising request must match the oldest expected step.
    always @(negedge clk) begin
        exp_t e;
        if (step_req && !req_q) begin
            if (sb.size() == 0) begin
                chk("req_expected", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("req_frame", frame_no, e.frame);
                chk("req_period", int'(period_out), e.period);
            end
        end
        req_q = step_req;
    end

    initial begin
        ack_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_ack && step_req) begin
                repeat (2) @(posedge clk);
                #1 ack_auto = 1'b1;
                @(posedge clk);
                #1 ack_auto = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int t;
        checks = 0; errors = 0; frame_no = 0; auto_ack = 1'b0; req_q = 1'b0;
        rst_n = 1'b0; vs = 1'b1; master_state = 2'd0; pause = 1'b0;
        score = 4'd0; ack_man = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_req", int'(step_req), 0);
        chk("rst_ovr", int'(overrun), 0);
        chk("rst_period", int'(period_out), 5);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Nominal cadence at score 0 with prompt ack.
        auto_ack = 1'b1;
        master_state = 2'd1;
        t = frame_no;
        push(t + 5, 5); push(t + 10, 5); push(t + 15, 5);
        frames(15);
        chk("nom_ovr", int'(overrun), 0);
        chk("nom_period", int'(period_out), 5);
        chk("nom_drain", sb.size(), 0);

        // Score change mid-period, then saturation at the floor.
        t = frame_no;
        frames(2);
        score = 4'd4;
        push(t + 5, 3);
        frames(4);
        score = 4'd15;
        push(t + 8, 1); push(t + 9, 1); push(t + 10, 1);
        frames(4);
        chk("floor_period", int'(period_out), 1);
        score = 4'd0;
        push(t + 11, 5);
        frames(1);
        chk("score_drain", sb.size(), 0);

        // Ack withheld for 7 frames -> overrun, single request.
        auto_ack = 1'b0;
        t = frame_no;
        push(t + 5, 5);
        frames(5);
        chk("ovr_pre", int'(overrun), 0);
        frames(5);
        chk("ovr_set", int'(overrun), 1);
        chk("ovr_req_held", int'(step_req), 1);
        frames(2);
        man_ack();
        push(t + 15, 5);
        auto_ack = 1'b1;
        frames(3);
        chk("ovr_sticky", int'(overrun), 1);
        chk("ovr_drain", sb.size(), 0);

        // Pause at counter = 2 for 10 frames.
        frames(2);
        pause = 1'b1;
        frames(10);
        chk("pause_noreq", int'(step_req), 0);
        pause = 1'b0;
        push(frame_no + 3, 5);
        frames(3);
        chk("pause_drain", sb.size(), 0);

        // Leave PLAY with an outstanding request.
        auto_ack = 1'b0;
        t = frame_no;
        push(t + 5, 5);
        frames(10);
        chk("lose_ovr_pre", int'(overrun), 1);
        @(posedge clk); #1 master_state = 2'd3;
        @(posedge clk); #1;
        chk("lose_req", int'(step_req), 0);
        chk("lose_ovr", int'(overrun), 0);
        frames(2);
        master_state = 2'd1;
        auto_ack = 1'b1;
        push(frame_no + 5, 5);
        frames(5);
        chk("replay_drain", sb.size(), 0);

        // Asynchronous reset during a request.
        auto_ack = 1'b0;
        score = 4'd4;
        push(frame_no + 5, 3);
        frames(5);
        chk("pre_rst_req", int'(step_req), 1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("async_rst_req", int'(step_req), 0);
        chk("async_rst_period", int'(period_out), 5);
        chk("final_drain", sb.size(), 0);
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
